// File: rtl/hex_scan_pkg.sv
// Shared types and defaults for the hex 7-segment scan driver.
package hex_scan_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam int DEF_DIGITS    = 4;
    localparam int DEF_SCAN_DIV  = 50000;
    localparam int DEF_GUARD_CYC = 16;

    // Pin level for one anode line given whether it should conduct.
    function automatic logic anode_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Per-slot cycle counter with guard-end and slot-end pulses.
module hex_scan_timer
    import hex_scan_pkg::*;
#(
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int GUARD_CYC = DEF_GUARD_CYC
) (
    input  logic clk,
    input  logic rst,
    output logic guard_end,
    output logic slot_end
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    assign guard_end = (cnt == CW'(GUARD_CYC - 1));
    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex scanner with frame-boundary load handshake.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int DIGITS           = DEF_DIGITS,
    parameter int SCAN_DIV         = DEF_SCAN_DIV,
    parameter int GUARD_CYC        = DEF_GUARD_CYC,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                       I_CLK,
    input  logic                       I_RST,
    input  logic [4*DIGITS-1:0]        I_VALUE,
    input  logic                       I_LOAD,
    output logic                       O_READY,
    output logic [3:0]                 O_CODE,
    output logic                       O_BLANK,
    output logic [DIGITS-1:0]          O_ANODE,
    output logic [$clog2(DIGITS)-1:0]  O_DIGIT_IDX
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic ACT_LOW = (ANODE_ACTIVE_LOW != 0);

    state_t              state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_nxt;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] next_val;
    logic                pending;
    logic                guard_end;
    logic                slot_end;
    logic                boundary;
    logic                lzb_blank;
    logic [3:0]          code_nxt;
    logic [DIGITS-1:0]   drive_anode;
    logic [DIGITS-1:0]   off_anode;

    hex_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD_CYC (GUARD_CYC)
    ) u_timer (
        .clk       (I_CLK),
        .rst       (I_RST),
        .guard_end (guard_end),
        .slot_end  (slot_end)
    );

    assign boundary = slot_end && (idx == LAST);
    assign idx_nxt  = (idx == LAST) ? '0 : idx + 1'b1;
    // The first slot of a new frame must already show the transferred value.
    assign next_val = (boundary && pending) ? shadow : active;
    assign code_nxt = 4'(next_val >> {idx_nxt, 2'b00});

`ifdef HEX_SCAN_LZB_EN
    assign lzb_blank = (idx != '0) && ((active >> {idx, 2'b00}) == '0);
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        drive_anode = '0;
        off_anode   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            off_anode[i]   = anode_level(1'b0, ACT_LOW);
            drive_anode[i] = anode_level((i == int'(idx)) && !lzb_blank, ACT_LOW);
        end
    end

    assign O_DIGIT_IDX = idx;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state   <= GUARD;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            O_READY <= 1'b1;
            O_CODE  <= '0;
            O_BLANK <= 1'b1;
            O_ANODE <= off_anode;
        end else begin
            if (I_LOAD && !pending) begin
                shadow  <= I_VALUE;
                pending <= 1'b1;
                O_READY <= 1'b0;
            end
            unique case (state)
                GUARD: begin
                    if (guard_end) begin
                        state   <= DRIVE;
                        O_ANODE <= drive_anode;
                        O_BLANK <= lzb_blank;
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state   <= GUARD;
                        idx     <= idx_nxt;
                        O_CODE  <= code_nxt;
                        O_ANODE <= off_anode;
                        O_BLANK <= 1'b1;
                        if (boundary && pending) begin
                            active  <= shadow;
                            pending <= 1'b0;
                            O_READY <= 1'b1;
                        end
                    end
                end
                default: state <= GUARD;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver: DIGITS=4, SCAN_DIV=8, GUARD_CYC=2, active-low.
module tb_hex_scan_driver;

`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        ready;
    logic [3:0]  code;
    logic        blank;
    logic [3:0]  anode;
    logic [1:0]  idx;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    hex_scan_driver #(
        .DIGITS           (4),
        .SCAN_DIV         (8),
        .GUARD_CYC        (2),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_VALUE     (value),
        .I_LOAD      (load),
        .O_READY     (ready),
        .O_CODE      (code),
        .O_BLANK     (blank),
        .O_ANODE     (anode),
        .O_DIGIT_IDX (idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // Cycle 0 is the interval right after the reset edge.
    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        do_reset();
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_idx", 32'(idx), 32'h0);
        goto(1);
        chk("guard1_anode", 32'(anode), 32'hF);
        goto(2);
        chk("c2_anode", 32'(anode), 32'hE);
        chk("c2_code", 32'(code), 32'h0);
        chk("c2_blank", 32'(blank), 32'h0);
        goto(8);
        chk("c8_idx", 32'(idx), 32'h1);
        chk("c8_anode", 32'(anode), 32'hF);
        goto(10);
        chk("c10_anode", 32'(anode), LZB ? 32'hF : 32'hD);

        do_reset();
        goto(5);
        do_load(16'h1A2F);
        chk("ld_ready6", 32'(ready), 32'h0);
        goto(31);
        chk("ld_ready31", 32'(ready), 32'h0);
        chk("ld_code31", 32'(code), 32'h0);
        goto(32);
        chk("ld_ready32", 32'(ready), 32'h1);
        chk("ld_code32", 32'(code), 32'hF);
        chk("ld_anode32", 32'(anode), 32'hF);
        goto(34);
        chk("ld_p0_code", 32'(code), 32'hF);
        chk("ld_p0_anode", 32'(anode), 32'hE);
        goto(42);
        chk("ld_p1_code", 32'(code), 32'h2);
        chk("ld_p1_anode", 32'(anode), 32'hD);
        goto(50);
        chk("ld_p2_code", 32'(code), 32'hA);
        chk("ld_p2_anode", 32'(anode), 32'hB);
        goto(58);
        chk("ld_p3_code", 32'(code), 32'h1);
        chk("ld_p3_anode", 32'(anode), 32'h7);
        chk("ld_p3_blank", 32'(blank), 32'h0);

        do_reset();
        goto(3);
        do_load(16'h1234);
        goto(10);
        do_load(16'h5555);
        chk("ign_ready", 32'(ready), 32'h0);
        goto(32);
        chk("ign_ready32", 32'(ready), 32'h1);
        goto(34);
        chk("ign_f1_p0", 32'(code), 32'h4);
        goto(42);
        chk("ign_f1_p1", 32'(code), 32'h3);
        goto(50);
        chk("ign_f1_p2", 32'(code), 32'h2);
        goto(58);
        chk("ign_f1_p3", 32'(code), 32'h1);
        goto(66);
        chk("ign_f2_p0", 32'(code), 32'h4);
        goto(90);
        chk("ign_f2_p3", 32'(code), 32'h1);

        do_reset();
        goto(31);
        do_load(16'h00A0);
        chk("bd_ready32", 32'(ready), 32'h0);
        chk("bd_code32", 32'(code), 32'h0);
        goto(42);
        chk("bd_f1_p1", 32'(code), 32'h0);
        goto(63);
        chk("bd_ready63", 32'(ready), 32'h0);
        goto(64);
        chk("bd_ready64", 32'(ready), 32'h1);
        chk("bd_code64", 32'(code), 32'h0);
        goto(74);
        chk("bd_f2_p1_code", 32'(code), 32'hA);
        chk("bd_f2_p1_anode", 32'(anode), 32'hD);
        chk("bd_f2_p1_blank", 32'(blank), 32'h0);

        do_reset();
        do_load(16'h0030);
        goto(34);
        chk("lz_p0_code", 32'(code), 32'h0);
        chk("lz_p0_anode", 32'(anode), 32'hE);
        chk("lz_p0_blank", 32'(blank), 32'h0);
        goto(42);
        chk("lz_p1_code", 32'(code), 32'h3);
        chk("lz_p1_anode", 32'(anode), 32'hD);
        goto(50);
        chk("lz_p2_blank", 32'(blank), LZB ? 32'h1 : 32'h0);
        chk("lz_p2_anode", 32'(anode), LZB ? 32'hF : 32'hB);
        goto(58);
        chk("lz_p3_blank", 32'(blank), LZB ? 32'h1 : 32'h0);
        chk("lz_p3_anode", 32'(anode), LZB ? 32'hF : 32'h7);

        do_reset();
        do_load(16'h0030);
        goto(33);
        do_load(16'h9876);
        goto(50);
        chk("mr_pre_ready", 32'(ready), 32'h0);
        chk("mr_pre_idx", 32'(idx), 32'h2);
        rst = 1'b1;
        step();
        chk("mr_ready", 32'(ready), 32'h1);
        chk("mr_anode", 32'(anode), 32'hF);
        chk("mr_blank", 32'(blank), 32'h1);
        chk("mr_code", 32'(code), 32'h0);
        chk("mr_idx", 32'(idx), 32'h0);
        rst = 1'b0;
        cyc = 0;
        goto(2);
        chk("mr_c2_anode", 32'(anode), 32'hE);
        chk("mr_c2_code", 32'(code), 32'h0);
        goto(34);
        chk("mr_f1_p0", 32'(code), 32'h0);
        chk("mr_f1_ready", 32'(ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
